md_unit: RTL and testbench

Multiply/divide responder for the pipelined MIPS core's EX stage. Consumes the 4-bit start code and the HI/LO select that the decoder generates, and owns the HI and LO registers. It runs the multi-cycle mult/multu/div/divu operations, performs mthi/mtlo writes, and returns the selected HI/LO value for mfhi/mflo. It exports busy so the hazard unit can stall later HI/LO-dependent instructions.

---
 rtl/md_unit.sv | 101 ++++++++++
 tb/tb_md_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit for the EX stage: multi-cycle mult/div with a
// busy flag for the hazard unit, plus single-cycle mthi/mtlo writes.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HLSel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic          busy_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   hi_reg, lo_reg, hi_tmp, lo_tmp;
    logic          wb_en_reg;

    logic          is_mul, is_div, div_zero;
    logic [63:0]   a_ext, b_ext, product;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic [31:0]   res_hi, res_lo;

    always_comb begin
        is_mul   = (start == OP_MULT) || (start == OP_MULTU);
        is_div   = (start == OP_DIV)  || (start == OP_DIVU);
        div_zero = (B == 32'd0);

        // Low 64 bits of a sign-extended product equal the signed product.
        a_ext   = (start == OP_MULT) ? {{32{A[31]}}, A} : {32'd0, A};
        b_ext   = (start == OP_MULT) ? {{32{B[31]}}, B} : {32'd0, B};
        product = a_ext * b_ext;

        // Signed divide via magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
        a_neg = (start == OP_DIV) && A[31];
        b_neg = (start == OP_DIV) && B[31];
        a_mag = a_neg ? (~A + 32'd1) : A;
        b_mag = b_neg ? (~B + 32'd1) : B;
        q_mag = div_zero ? 32'd0 : (a_mag / b_mag);
        r_mag = div_zero ? 32'd0 : (a_mag % b_mag);
        quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

        res_hi = is_mul ? product[63:32] : rem;
        res_lo = is_mul ? product[31:0]  : quot;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg  <= 1'b0;
            count_reg <= '0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            hi_tmp    <= 32'd0;
            lo_tmp    <= 32'd0;
            wb_en_reg <= 1'b0;
        end else if (busy_reg) begin
            // Every start code is ignored while an operation is in flight.
            count_reg <= count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
                busy_reg <= 1'b0;
                if (wb_en_reg) begin
                    hi_reg <= hi_tmp;
                    lo_reg <= lo_tmp;
                end
            end
        end else begin
            if (is_mul || is_div) begin
                hi_tmp    <= res_hi;
                lo_tmp    <= res_lo;
                wb_en_reg <= !(is_div && div_zero);
                count_reg <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                busy_reg  <= 1'b1;
            end else if (start == OP_MTHI) begin
                hi_reg <= A;
            end else if (start == OP_MTLO) begin
                lo_reg <= A;
            end
        end
    end

    assign busy  = busy_reg;
    assign HI    = hi_reg;
    assign LO    = lo_reg;
    assign MDout = HLSel ? hi_reg : lo_reg;
endmodule

// File: tb/tb_md_unit.sv
// Directed table-driven bench for md_unit with hand sequences for
// in-flight ignore and asynchronous reset during an operation.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  start = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        HLSel = 1'b0;
    logic        busy;
    logic [31:0] HI, LO, MDout;

    int errors = 0;
    int checks = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .HLSel(HLSel), .busy(busy), .HI(HI), .LO(LO), .MDout(MDout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        check({name, " HI"}, HI, ehi);
        check({name, " LO"}, LO, elo);
        HLSel = 1'b1; #1;
        check({name, " MDout(HI)"}, MDout, ehi);
        HLSel = 1'b0; #1;
        check({name, " MDout(LO)"}, MDout, elo);
    endtask

    // Present an op for one edge, then count busy cycles sampled at negedges.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        int guard;
        @(negedge clk);
        start = op; A = a; B = b;
        @(negedge clk);
        start = 4'd0;
        cyc = 0;
        guard = 0;
        while (busy && guard < 100) begin
            cyc++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) begin
            errors++;
            $display("FAIL %s: busy stuck high, got timeout expected release", "busy_timeout");
        end
    endtask

    initial begin
        int cyc;
        int guard;

        vecs[0]  = '{"mult",       4'd1,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{"multu",      4'd2,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{"div -7/2",   4'd3,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{"divu 7/2",   4'd4,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{"div ovf",    4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{"divu by 0",  4'd4,  32'h00001234, 32'h00000000, 32'h00000000, 32'h80000000, 10};
        vecs[6]  = '{"mthi",       4'd7,  32'h12345678, 32'h00000000, 32'h12345678, 32'h80000000, 0};
        vecs[7]  = '{"mtlo",       4'd8,  32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 0};
        vecs[8]  = '{"mfhi",       4'd5,  32'h55555555, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 0};
        vecs[9]  = '{"code 12",    4'd12, 32'h55555555, 32'h66666666, 32'h12345678, 32'h9ABCDEF0, 0};
        vecs[10] = '{"mult 2^32",  4'd1,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[11] = '{"div 7/-2",   4'd3,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};

        // Power-on reset
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check_outputs("reset", 32'd0, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            $display("vec %0d %s: HI=0x%08h LO=0x%08h busy_cycles=%0d", i, vecs[i].name, HI, LO, cyc);
            check({vecs[i].name, " cycles"}, 32'(cyc), 32'(vecs[i].cyc));
            check_outputs(vecs[i].name, vecs[i].hi, vecs[i].lo);
        end

        // Back-to-back ops; the second is presented right after busy falls.
        run_op(4'd2, 32'd6, 32'd7, cyc);
        run_op(4'd2, 32'd3, 32'd9, cyc);
        $display("seq back-to-back: HI=0x%08h LO=0x%08h busy_cycles=%0d", HI, LO, cyc);
        check("b2b cycles", 32'(cyc), 32'd5);
        check_outputs("b2b", 32'd0, 32'd27);

        // Start codes presented while busy must be ignored.
        @(negedge clk);
        start = 4'd1; A = 32'd3; B = 32'd5;
        cyc = 0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (busy) cyc++;
            start = 4'd0;
            if (cyc == 2) begin start = 4'd7; A = 32'hDEAD0000; end
            if (cyc == 3) begin start = 4'd3; A = 32'h00000064; B = 32'h00000003; end
        end while ((busy || guard < 2) && guard < 100);
        start = 4'd0;
        $display("seq ignore-while-busy: HI=0x%08h LO=0x%08h busy_cycles=%0d", HI, LO, cyc);
        check("ignore cycles", 32'(cyc), 32'd5);
        check_outputs("ignore", 32'd0, 32'd15);
        check("ignore idle busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset on the third busy cycle, mid-cycle.
        @(negedge clk);
        start = 4'd1; A = 32'h00000010; B = 32'h00000010;
        @(negedge clk);
        start = 4'd0;
        repeat (2) @(negedge clk);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        $display("seq async reset: busy=%0b HI=0x%08h LO=0x%08h", busy, HI, LO);
        check("async busy", {31'd0, busy}, 32'd0);
        check("async HI", HI, 32'd0);
        check("async LO", LO, 32'd0);
        check("async MDout", MDout, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        $display("seq post-reset: busy=%0b HI=0x%08h LO=0x%08h", busy, HI, LO);
        check("post busy", {31'd0, busy}, 32'd0);
        check_outputs("post-reset", 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
